// File: rtl/sdram_avalon_arbiter.sv
// Purpose: round-robin arbiter sharing one SDRAM Avalon-MM slave between two masters, routing read data by tag.
// Latency: a request seen in IDLE reaches the slave next cycle; owner handover is back-to-back; read data path is combinational.
// Backpressure: owner waitrequest follows s_waitrequest; reads also stall when MAX_PEND reads are outstanding; non-owners always see waitrequest.
//
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   m0_*/m1_* address/read/write/...     master commands in; waitrequest, readdata, readdatavalid out
//   s_* address/read/write/...           command to the SDRAM slave; s_waitrequest/readdata/readdatavalid back
//   pending                              number of outstanding reads
//   err                                  sticky protocol error (read+write together, or a response with nothing outstanding)
module sdram_avalon_arbiter #(
    parameter int ADDR_W   = 25,
    parameter int DATA_W   = 32,
    parameter int MAX_PEND = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic [ADDR_W-1:0]       m0_address,
    input  logic                    m0_read,
    input  logic                    m0_write,
    input  logic [DATA_W-1:0]       m0_writedata,
    input  logic [DATA_W/8-1:0]     m0_byteenable,
    output logic                    m0_waitrequest,
    output logic [DATA_W-1:0]       m0_readdata,
    output logic                    m0_readdatavalid,

    input  logic [ADDR_W-1:0]       m1_address,
    input  logic                    m1_read,
    input  logic                    m1_write,
    input  logic [DATA_W-1:0]       m1_writedata,
    input  logic [DATA_W/8-1:0]     m1_byteenable,
    output logic                    m1_waitrequest,
    output logic [DATA_W-1:0]       m1_readdata,
    output logic                    m1_readdatavalid,

    output logic [ADDR_W-1:0]       s_address,
    output logic                    s_read,
    output logic                    s_write,
    output logic [DATA_W-1:0]       s_writedata,
    output logic [DATA_W/8-1:0]     s_byteenable,
    input  logic                    s_waitrequest,
    input  logic [DATA_W-1:0]       s_readdata,
    input  logic                    s_readdatavalid,

    output logic [$clog2(MAX_PEND):0] pending,
    output logic                    err
);

    localparam int PW = $clog2(MAX_PEND);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(MAX_PEND);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t              state, state_nxt;
    logic                rr, rr_nxt;
    logic                req0, req1;
    logic                own_vld, own_id;
    logic                own_read, own_write;
    logic                own_req, oth_req;
    logic                throttle, accept;
    logic                push, pop, spurious;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [MAX_PEND-1:0] tag_mem;
    logic                head;

    assign req0     = m0_read | m0_write;
    assign req1     = m1_read | m1_write;
    assign own_vld  = (state != IDLE);
    assign own_id   = (state == OWN1);
    assign own_read  = own_id ? m1_read  : m0_read;
    assign own_write = own_id ? m1_write : m0_write;
    assign own_req  = own_id ? req1 : req0;
    assign oth_req  = own_id ? req0 : req1;

    // Command mux: the slave always sees the owner's fields; read/write strobes are gated.
    assign s_address    = own_id ? m1_address    : m0_address;
    assign s_writedata  = own_id ? m1_writedata  : m0_writedata;
    assign s_byteenable = own_id ? m1_byteenable : m0_byteenable;

    // A read with the tag FIFO full is held back; a read+write combination forwards only the read.
    assign throttle = own_vld & own_read & (pending == FULL);
    assign s_read   = own_vld & own_read & ~throttle;
    assign s_write  = own_vld & own_write & ~own_read;
    assign accept   = (s_read | s_write) & ~s_waitrequest;

    assign m0_waitrequest = (state != OWN0) | throttle | s_waitrequest;
    assign m1_waitrequest = (state != OWN1) | throttle | s_waitrequest;

    // Response routing: the head tag names the master that issued the oldest outstanding read.
    assign push     = accept & s_read;
    assign pop      = s_readdatavalid & (pending != '0);
    assign spurious = s_readdatavalid & (pending == '0);
    assign head     = tag_mem[rd_ptr];

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = pop & ~head;
    assign m1_readdatavalid = pop & head;

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        if (accept) begin
            rr_nxt = ~own_id;
            if (oth_req)
                state_nxt = own_id ? OWN0 : OWN1;
            else if (own_req)
                state_nxt = state;
            else
                state_nxt = IDLE;
        end else if (!own_vld || !own_req) begin
            // Nobody to wait for: arbitrate afresh. A stalled owner keeps the slave.
            if (req0 && req1)
                state_nxt = rr ? OWN1 : OWN0;
            else if (req0)
                state_nxt = OWN0;
            else if (req1)
                state_nxt = OWN1;
            else
                state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            rr      <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            rr    <= rr_nxt;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                pending <= pending + CW'(1);
            else if (pop && !push)
                pending <= pending - CW'(1);
            if (spurious || (own_vld && own_read && own_write))
                err <= 1'b1;
        end
    end

    // Tag storage needs no reset: entries are only read behind a valid pending count.
    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr] <= own_id;
    end

endmodule

// File: tb/tb_sdram_avalon_arbiter.sv
// Purpose: self-checking bench for sdram_avalon_arbiter using a queue-based reference model plus directed literal checks.
// Latency: inputs change 1 time unit after each rising edge; outputs are compared on the falling edge.
// Backpressure: the bench plays the SDRAM slave, driving s_waitrequest and s_readdatavalid directly.
module tb_sdram_avalon_arbiter;

    localparam int ADDR_W   = 25;
    localparam int DATA_W   = 32;
    localparam int MAX_PEND = 4;
    localparam int BE_W     = DATA_W / 8;
    localparam int CW       = $clog2(MAX_PEND) + 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] m0_address, m1_address, s_address;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
    logic [BE_W-1:0]   m0_byteenable, m1_byteenable, s_byteenable;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic              s_read, s_write, s_waitrequest, s_readdatavalid;
    logic [CW-1:0]     pending;
    logic              err;

    int tests = 0;
    int fails = 0;

    // Reference model: current owner (-1 = none), preferred master, outstanding tags, error flag.
    int owner_m = -1;
    int rr_m    = 0;
    int q[$];
    bit err_m   = 1'b0;

    always #5 clk = ~clk;

    sdram_avalon_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .pending(pending), .err(err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
    endtask

    // Every-cycle comparison against the model, then advance the model to the next edge.
    always @(negedge clk) begin
        logic [1:0] rd, wr, req, exp_wait, exp_rdv;
        logic       exp_sr, exp_sw, full, acc;
        int         o;
        if (!reset_n) begin
            owner_m = -1;
            rr_m    = 0;
            q.delete();
            err_m   = 1'b0;
            check("rst_s_read", s_read, 0);
            check("rst_s_write", s_write, 0);
            check("rst_wait", {m1_waitrequest, m0_waitrequest}, 2'b11);
            check("rst_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
            check("rst_pending", pending, 0);
            check("rst_err", err, 0);
        end else begin
            rd       = {m1_read, m0_read};
            wr       = {m1_write, m0_write};
            req      = rd | wr;
            exp_sr   = 1'b0;
            exp_sw   = 1'b0;
            exp_wait = 2'b11;
            exp_rdv  = 2'b00;
            full     = (q.size() == MAX_PEND);
            o        = owner_m;
            if (o >= 0) begin
                exp_sr      = rd[o] && !full;
                exp_sw      = wr[o] && !rd[o];
                exp_wait[o] = (rd[o] && full) ? 1'b1 : s_waitrequest;
            end
            if (s_readdatavalid && q.size() > 0)
                exp_rdv[q[0]] = 1'b1;

            check("m_s_read", s_read, exp_sr);
            check("m_s_write", s_write, exp_sw);
            check("m_wait", {m1_waitrequest, m0_waitrequest}, exp_wait);
            check("m_rdv", {m1_readdatavalid, m0_readdatavalid}, exp_rdv);
            check("m_pending", pending, q.size());
            check("m_err", err, err_m);
            check("m_readdata0", m0_readdata, s_readdata);
            check("m_readdata1", m1_readdata, s_readdata);
            if (exp_sr || exp_sw) begin
                check("m_s_address", s_address, (o == 1) ? m1_address : m0_address);
                if (exp_sw) begin
                    check("m_s_writedata", s_writedata, (o == 1) ? m1_writedata : m0_writedata);
                    check("m_s_byteenable", s_byteenable, (o == 1) ? m1_byteenable : m0_byteenable);
                end
            end

            acc = (exp_sr || exp_sw) && !s_waitrequest;
            if (s_readdatavalid) begin
                if (q.size() > 0)
                    void'(q.pop_front());
                else
                    err_m = 1'b1;
            end
            if (o >= 0 && rd[o] && wr[o])
                err_m = 1'b1;
            if (acc) begin
                if (exp_sr)
                    q.push_back(o);
                rr_m = 1 - o;
                if (req[1-o])
                    owner_m = 1 - o;
                else if (req[o])
                    owner_m = o;
                else
                    owner_m = -1;
            end else if (o < 0 || !req[o]) begin
                if (req == 2'b11)
                    owner_m = rr_m;
                else if (req[0])
                    owner_m = 0;
                else if (req[1])
                    owner_m = 1;
                else
                    owner_m = -1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
        tick;
        tick;
        at_neg;
        check("reset_pending", pending, 0);
        check("reset_m0_wait", m0_waitrequest, 1);
        tick;
        reset_n = 1'b1;

        // Master 0 single write.
        m0_address = 25'h10; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF; m0_write = 1;
        at_neg;
        check("wr_idle_m0_wait", m0_waitrequest, 1);
        check("wr_idle_s_write", s_write, 0);
        tick;
        at_neg;
        check("wr_s_write", s_write, 1);
        check("wr_s_address", s_address, 25'h10);
        check("wr_s_writedata", s_writedata, 32'hDEADBEEF);
        check("wr_m0_wait", m0_waitrequest, 0);
        tick;
        m0_write = 0;
        tick;
        tick;

        // Master 1 write held off by s_waitrequest for five cycles.
        m1_address = 25'h40; m1_writedata = 32'h12345678; m1_byteenable = 4'h3; m1_write = 1;
        s_waitrequest = 1;
        tick;
        for (int i = 1; i <= 5; i++) begin
            at_neg;
            check("stall_m1_wait", m1_waitrequest, 1);
            check("stall_m0_wait", m0_waitrequest, 1);
            check("stall_s_write", s_write, 1);
            check("stall_s_address", s_address, 25'h40);
            tick;
        end
        s_waitrequest = 0;
        at_neg;
        check("stall_accept_m1_wait", m1_waitrequest, 0);
        check("stall_accept_m0_wait", m0_waitrequest, 1);
        check("stall_s_byteenable", s_byteenable, 4'h3);
        tick;
        m1_write = 0;
        tick;
        tick;

        // Both masters read continuously: grants alternate starting with master 0.
        m0_address = 25'h100; m1_address = 25'h200; m0_read = 1; m1_read = 1;
        at_neg;
        check("rd_idle_pending", pending, 0);
        tick;
        for (int i = 0; i < 4; i++) begin
            at_neg;
            check("rd_grant_m0_wait", m0_waitrequest, (i % 2 == 0) ? 0 : 1);
            check("rd_grant_m1_wait", m1_waitrequest, (i % 2 == 0) ? 1 : 0);
            check("rd_pending", pending, i);
            check("rd_s_read", s_read, 1);
            tick;
        end
        m1_read = 0;
        at_neg;
        check("rd_full_pending", pending, 4);
        check("rd_full_s_read", s_read, 0);
        check("rd_full_m0_wait", m0_waitrequest, 1);
        tick;

        // Responses return in order: tags 0,1,0,1 then the read accepted during the pop.
        s_readdatavalid = 1; s_readdata = 32'hA0;
        at_neg;
        check("rsp0_m0_rdv", m0_readdatavalid, 1);
        check("rsp0_m1_rdv", m1_readdatavalid, 0);
        check("rsp0_m0_data", m0_readdata, 32'hA0);
        check("rsp0_m0_wait", m0_waitrequest, 1);
        tick;
        s_readdata = 32'hA1;
        at_neg;
        check("rsp1_m1_rdv", m1_readdatavalid, 1);
        check("rsp1_m0_rdv", m0_readdatavalid, 0);
        check("rsp1_pending", pending, 3);
        check("rsp1_s_read", s_read, 1);
        tick;
        m0_read = 0; s_readdata = 32'hA2;
        at_neg;
        check("rsp2_pushpop_pending", pending, 3);
        check("rsp2_m0_rdv", m0_readdatavalid, 1);
        tick;
        s_readdata = 32'hA3;
        at_neg;
        check("rsp3_m1_rdv", m1_readdatavalid, 1);
        check("rsp3_pending", pending, 2);
        tick;
        s_readdata = 32'hA4;
        at_neg;
        check("rsp4_m0_rdv", m0_readdatavalid, 1);
        check("rsp4_pending", pending, 1);
        tick;

        // Spurious response with nothing outstanding.
        s_readdata = 32'hEE;
        at_neg;
        check("spur_pending", pending, 0);
        check("spur_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
        check("spur_err_before", err, 0);
        tick;
        s_readdatavalid = 0;
        at_neg;
        check("spur_err_set", err, 1);
        tick;
        tick;
        at_neg;
        check("spur_err_sticky", err, 1);
        tick;

        // Reset, then read+write together from master 0 and three reads outstanding.
        reset_n = 0;
        tick;
        at_neg;
        check("rst2_err", err, 0);
        tick;
        reset_n = 1;
        m0_address = 25'h300; m0_writedata = 32'h55AA55AA; m0_read = 1; m0_write = 1;
        tick;
        at_neg;
        check("rdwr_s_read", s_read, 1);
        check("rdwr_s_write", s_write, 0);
        check("rdwr_s_address", s_address, 25'h300);
        tick;
        m0_write = 0;
        at_neg;
        check("rdwr_err", err, 1);
        tick;
        tick;
        s_waitrequest = 1; m1_read = 1;
        at_neg;
        check("pre_rst_pending", pending, 3);
        #2;
        reset_n = 0;
        #1;
        check("async_rst_pending", pending, 0);
        check("async_rst_s_read", s_read, 0);
        check("async_rst_wait", {m1_waitrequest, m0_waitrequest}, 2'b11);
        check("async_rst_err", err, 0);
        tick;
        at_neg;
        tick;
        reset_n = 1; s_waitrequest = 0;
        at_neg;
        check("rearb_idle_wait", {m1_waitrequest, m0_waitrequest}, 2'b11);
        tick;
        at_neg;
        check("rearb_m0_wait", m0_waitrequest, 0);
        check("rearb_m1_wait", m1_waitrequest, 1);
        check("rearb_s_address", s_address, 25'h300);
        tick;
        m0_read = 0; m1_read = 0;
        tick;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
